// File: rtl/mips_defs.sv
// Shared MIPS core constants for the fetch stage: reset/exception addresses,
// instruction-memory window, exception codes and the fetch-address check.
// No logic state; pure constants and one combinational helper.
package mips_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFF;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    // CP0 ExcCode values used by the fetch stage.
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    // A fetch is bad when it is misaligned or falls outside the IM window.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
    endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch-stage bundle: D-stage redirect controls, IM read port and IF/ID outputs.
// slave = fetch_pc's view; master = the surrounding pipeline (or a testbench).
// No handshake; stall is the only hold control, flush comes from exc/eret.
interface fetch_pc_if;
    import mips_defs::*;

    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] im_rdata;

    logic [31:0] pc_F;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic        valid_D;
    logic        adel_D;

    modport slave (
        input  stall, br_valid, br_target, exc_req, eret_req, epc, im_rdata,
        output pc_F, Instr_D, PC_D, PC4_D, valid_D, adel_D
    );

    modport master (
        output stall, br_valid, br_target, exc_req, eret_req, epc, im_rdata,
        input  pc_F, Instr_D, PC_D, PC4_D, valid_D, adel_D
    );
endinterface

// File: rtl/fetch_pc_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush controls.
// Latency: one cycle from load/flush to outputs; all outputs registered.
// Backpressure: load=0 and flush=0 holds every field (hazard-unit stall).
module if_id_reg
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,      // synchronous, active-low
    input  logic        load,
    input  logic        flush,      // wins over load
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    input  logic [31:0] instr,
    input  logic        adel,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic        adel_d
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_d <= NOP;
            pc_d    <= 32'h0;
            pc4_d   <= 32'h0;
            valid_d <= 1'b0;
            adel_d  <= 1'b0;
        end else if (flush) begin
            // Bubble keeps the PC of the squashed fetch for debug/EPC tracing.
            instr_d <= NOP;
            pc_d    <= pc;
            pc4_d   <= pc4;
            valid_d <= 1'b0;
            adel_d  <= 1'b0;
        end else if (load) begin
            instr_d <= instr;
            pc_d    <= pc;
            pc4_d   <= pc4;
            valid_d <= 1'b1;
            adel_d  <= adel;
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// Fetch PC register, next-PC priority mux, fetch address check, IF/ID register.
// Latency: redirect at edge N shows on pc_F after N; its instruction in D after N+1.
// Backpressure: stall freezes PC and IF/ID unless an exception or reset intervenes.
// Ports: clk, reset (sync active-low), bus (fetch_pc_if.slave).
module fetch_pc
    import mips_defs::*;
(
    input  logic          clk,
    input  logic          reset,
    fetch_pc_if.slave     bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic [31:0] pc_plus4;
    logic        bad;
    logic        ifid_load;
    logic        ifid_flush;

    assign pc_plus4 = pc_q + 32'd4;   // wraps modulo 2^32
    assign bad      = fetch_addr_bad(pc_q);

    // Priority: exc > eret (only when not stalled) > stall > branch > sequential.
    always_comb begin
        pc_nxt     = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (bus.exc_req) begin
            pc_nxt     = EXC_VECTOR;
            ifid_flush = 1'b1;
        end else if (bus.eret_req && !bus.stall) begin
            // eret has no delay slot, so the fetch in flight is squashed.
            pc_nxt     = bus.epc;
            ifid_flush = 1'b1;
        end else if (bus.stall) begin
            pc_nxt     = pc_q;
        end else if (bus.br_valid) begin
            // Delay slot currently at pc_F still loads into IF/ID.
            pc_nxt     = bus.br_target;
            ifid_load  = 1'b1;
        end else begin
            pc_nxt     = pc_plus4;
            ifid_load  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_nxt;
        end
    end

    // Bad fetches keep sequencing; they are tagged and carry a NOP instead.
    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .pc      (pc_q),
        .pc4     (pc_plus4),
        .instr   (bad ? NOP : bus.im_rdata),
        .adel    (bad),
        .instr_d (bus.Instr_D),
        .pc_d    (bus.PC_D),
        .pc4_d   (bus.PC4_D),
        .valid_d (bus.valid_D),
        .adel_d  (bus.adel_D)
    );

    assign bus.pc_F = pc_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed testbench for fetch_pc: reset, sequencing, branch, stall, exc, eret,
// address-error tagging, mid-run reset and PC wrap.
// Instruction memory is modelled as im_rdata = pc_F ^ 32'hDEAD_0000.
module tb_fetch_pc;

    logic clk = 1'b0;
    logic reset;
    int   n_tests  = 0;
    int   n_failed = 0;

    fetch_pc_if bus ();

    fetch_pc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.im_rdata = bus.pc_F ^ 32'hDEAD_0000;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_target = 32'h0;
        bus.exc_req   = 1'b0;
        bus.eret_req  = 1'b0;
        bus.epc       = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.br_valid = 1'b1;
        bus.br_target = 32'h0000_3100;
        reset = 1'b0;
        step();
        step();
        n_tests++; if (bus.pc_F !== 32'h0000_3000) begin n_failed++; $display("FAIL reset_pc got %h want %h", bus.pc_F, 32'h0000_3000); end
        n_tests++; if (bus.valid_D !== 1'b0) begin n_failed++; $display("FAIL reset_valid got %b want 0", bus.valid_D); end
        n_tests++; if (bus.Instr_D !== 32'h0) begin n_failed++; $display("FAIL reset_instr got %h want 0", bus.Instr_D); end
        n_tests++; if (bus.PC_D !== 32'h0 || bus.PC4_D !== 32'h0) begin n_failed++; $display("FAIL reset_pcd got %h/%h want 0/0", bus.PC_D, bus.PC4_D); end
        n_tests++; if (bus.adel_D !== 1'b0) begin n_failed++; $display("FAIL reset_adel got %b want 0", bus.adel_D); end
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h0000_3000; exp_pc[1] = 32'h0000_3004;
        exp_pc[2] = 32'h0000_3008; exp_pc[3] = 32'h0000_300C;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (bus.pc_F !== exp_pc[i]) begin n_failed++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc_F, exp_pc[i]); end
            if (i > 0) begin
                n_tests++;
                if (bus.PC_D !== exp_pc[i-1] || bus.PC4_D !== exp_pc[i] || bus.valid_D !== 1'b1 || bus.Instr_D !== mem(exp_pc[i-1])) begin
                    n_failed++;
                    $display("FAIL seq_ifid[%0d] got pc=%h pc4=%h v=%b ins=%h want pc=%h pc4=%h v=1 ins=%h",
                             i, bus.PC_D, bus.PC4_D, bus.valid_D, bus.Instr_D, exp_pc[i-1], exp_pc[i], mem(exp_pc[i-1]));
                end
            end
            step();
        end
    endtask

    task automatic test_branch();
        // Taken: delay slot 3008 enters D while target 3020 is fetched.
        do_reset(); step(); step();
        bus.br_valid = 1'b1; bus.br_target = 32'h0000_3020;
        step();
        bus.br_valid = 1'b0;
        n_tests++; if (bus.pc_F !== 32'h0000_3020) begin n_failed++; $display("FAIL br_taken_pc got %h want 00003020", bus.pc_F); end
        n_tests++; if (bus.PC_D !== 32'h0000_3008 || bus.valid_D !== 1'b1) begin n_failed++; $display("FAIL br_delay_slot got %h v=%b want 00003008 v=1", bus.PC_D, bus.valid_D); end
        step();
        n_tests++; if (bus.pc_F !== 32'h0000_3024 || bus.PC_D !== 32'h0000_3020) begin n_failed++; $display("FAIL br_target_in_d got pc=%h pcd=%h want 00003024/00003020", bus.pc_F, bus.PC_D); end
        // Not taken: br_target is simply the sequential address.
        do_reset(); step(); step();
        bus.br_valid = 1'b1; bus.br_target = 32'h0000_300C;
        step();
        bus.br_valid = 1'b0;
        step();
        n_tests++; if (bus.pc_F !== 32'h0000_3010 || bus.PC_D !== 32'h0000_300C) begin n_failed++; $display("FAIL br_not_taken got pc=%h pcd=%h want 00003010/0000300c", bus.pc_F, bus.PC_D); end
    endtask

    task automatic test_stall();
        do_reset(); step(); step();
        bus.stall = 1'b1; bus.br_valid = 1'b1; bus.br_target = 32'h0000_3040;
        bus.eret_req = 1'b1; bus.epc = 32'h0000_3050;
        step(); step();
        n_tests++; if (bus.pc_F !== 32'h0000_3008) begin n_failed++; $display("FAIL stall_pc got %h want 00003008", bus.pc_F); end
        n_tests++;
        if (bus.PC_D !== 32'h0000_3004 || bus.PC4_D !== 32'h0000_3008 || bus.valid_D !== 1'b1 || bus.Instr_D !== mem(32'h0000_3004)) begin
            n_failed++;
            $display("FAIL stall_ifid got pc=%h pc4=%h v=%b ins=%h want 00003004/00003008/1/%h",
                     bus.PC_D, bus.PC4_D, bus.valid_D, bus.Instr_D, mem(32'h0000_3004));
        end
        bus.stall = 1'b0; bus.eret_req = 1'b0;
        step();
        bus.br_valid = 1'b0;
        n_tests++; if (bus.pc_F !== 32'h0000_3040 || bus.PC_D !== 32'h0000_3008) begin n_failed++; $display("FAIL stall_release got pc=%h pcd=%h want 00003040/00003008", bus.pc_F, bus.PC_D); end
    endtask

    task automatic test_exc();
        do_reset(); step(); step();
        bus.exc_req = 1'b1; bus.stall = 1'b1; bus.eret_req = 1'b1; bus.epc = 32'h0000_3050;
        step();
        idle_inputs();
        n_tests++; if (bus.pc_F !== 32'h0000_4180) begin n_failed++; $display("FAIL exc_pc got %h want 00004180", bus.pc_F); end
        n_tests++; if (bus.valid_D !== 1'b0 || bus.Instr_D !== 32'h0 || bus.adel_D !== 1'b0) begin n_failed++; $display("FAIL exc_flush got v=%b ins=%h adel=%b want 0/0/0", bus.valid_D, bus.Instr_D, bus.adel_D); end
        n_tests++; if (bus.PC_D !== 32'h0000_3008) begin n_failed++; $display("FAIL exc_pcd got %h want 00003008", bus.PC_D); end
        step();
        n_tests++; if (bus.pc_F !== 32'h0000_4184 || bus.PC_D !== 32'h0000_4180 || bus.valid_D !== 1'b1 || bus.Instr_D !== mem(32'h0000_4180)) begin n_failed++; $display("FAIL exc_handler got pc=%h pcd=%h v=%b ins=%h", bus.pc_F, bus.PC_D, bus.valid_D, bus.Instr_D); end
    endtask

    task automatic test_eret();
        do_reset(); step(); step();
        bus.eret_req = 1'b1; bus.epc = 32'h0000_3010;
        step();
        idle_inputs();
        n_tests++; if (bus.pc_F !== 32'h0000_3010) begin n_failed++; $display("FAIL eret_pc got %h want 00003010", bus.pc_F); end
        n_tests++; if (bus.valid_D !== 1'b0 || bus.Instr_D !== 32'h0) begin n_failed++; $display("FAIL eret_bubble got v=%b ins=%h want 0/0", bus.valid_D, bus.Instr_D); end
        step();
        n_tests++; if (bus.pc_F !== 32'h0000_3014 || bus.PC_D !== 32'h0000_3010 || bus.valid_D !== 1'b1) begin n_failed++; $display("FAIL eret_resume got pc=%h pcd=%h v=%b", bus.pc_F, bus.PC_D, bus.valid_D); end
    endtask

    task automatic test_adel();
        logic [31:0] tgt   [4];
        logic        exp_b [4];
        tgt[0] = 32'h0000_3002; exp_b[0] = 1'b1;   // misaligned
        tgt[1] = 32'h0000_7000; exp_b[1] = 1'b1;   // just above IM_HI
        tgt[2] = 32'h0000_6FFC; exp_b[2] = 1'b0;   // last legal word
        tgt[3] = 32'h0000_2FFC; exp_b[3] = 1'b1;   // just below IM_LO
        for (int i = 0; i < 4; i++) begin
            do_reset();
            bus.br_valid = 1'b1; bus.br_target = tgt[i];
            step();
            bus.br_valid = 1'b0;
            step();
            n_tests++;
            if (bus.PC_D !== tgt[i] || bus.adel_D !== exp_b[i] || bus.valid_D !== 1'b1 ||
                bus.Instr_D !== (exp_b[i] ? 32'h0 : mem(tgt[i])) || bus.pc_F !== tgt[i] + 32'd4) begin
                n_failed++;
                $display("FAIL adel[%0d] got pcd=%h adel=%b v=%b ins=%h pc=%h want pcd=%h adel=%b",
                         i, bus.PC_D, bus.adel_D, bus.valid_D, bus.Instr_D, bus.pc_F, tgt[i], exp_b[i]);
            end
            if (exp_b[i]) begin
                bus.exc_req = 1'b1;
                step();
                bus.exc_req = 1'b0;
                n_tests++; if (bus.pc_F !== 32'h0000_4180 || bus.adel_D !== 1'b0 || bus.valid_D !== 1'b0) begin n_failed++; $display("FAIL adel_exc[%0d] got pc=%h adel=%b v=%b want 00004180/0/0", i, bus.pc_F, bus.adel_D, bus.valid_D); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); step(); step(); step();
        bus.exc_req = 1'b1; bus.br_valid = 1'b1; bus.br_target = 32'h0000_3200;
        reset = 1'b0;
        step();
        n_tests++; if (bus.pc_F !== 32'h0000_3000 || bus.valid_D !== 1'b0 || bus.PC_D !== 32'h0 || bus.PC4_D !== 32'h0) begin n_failed++; $display("FAIL reset_mid got pc=%h v=%b pcd=%h pc4=%h want 00003000/0/0/0", bus.pc_F, bus.valid_D, bus.PC_D, bus.PC4_D); end
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.br_valid = 1'b1; bus.br_target = 32'hFFFF_FFFC;
        step();
        bus.br_valid = 1'b0;
        step();
        n_tests++; if (bus.pc_F !== 32'h0 || bus.PC4_D !== 32'h0 || bus.PC_D !== 32'hFFFF_FFFC || bus.adel_D !== 1'b1) begin n_failed++; $display("FAIL wrap got pc=%h pc4=%h pcd=%h adel=%b want 0/0/fffffffc/1", bus.pc_F, bus.PC4_D, bus.PC_D, bus.adel_D); end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_exc();
        test_eret();
        test_adel();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Fetch-stage program counter and IF/ID pipeline register for the five-stage MIPS core. It consumes the next-PC value computed by the D-stage branch unit, decides the next fetch address by priority, and presents the fetched instruction to decode with its PC+4. It also checks the fetch address for alignment and range, and tags bad fetches for the exception unit.

## Interface
- `RESET_PC`, 32'h0000_3000: first fetch address.
- `EXC_VECTOR`, 32'h0000_4180: exception handler entry.
- `IM_LO`, 32'h0000_3000: lowest legal fetch address.
- `IM_HI`, 32'h0000_6FFF: highest legal fetch address.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `stall`, in, 1: hazard-unit freeze of PC and IF/ID.
- `br_valid`, in, 1: D holds a branch or jump; `br_target` is meaningful.
- `br_target`, in, 32: next PC from the branch unit (taken target, or PC4_D+4).
- `exc_req`, in, 1: exception or interrupt taken this cycle.
- `eret_req`, in, 1: D holds `eret`.
- `epc`, in, 32: return address from CP0.
- `im_rdata`, in, 32: instruction memory data at `pc_F` (combinational read).
- `pc_F`, out, 32: current fetch address, drives IM.
- `Instr_D`, out, 32: IF/ID instruction.
- `PC_D`, out, 32: IF/ID PC.
- `PC4_D`, out, 32: IF/ID PC+4.
- `valid_D`, out, 1: IF/ID slot holds a real instruction (0 = bubble).
- `adel_D`, out, 1: fetch address error tagged on the D-stage instruction (ExcCode 4).

## Operation
- Per-cycle priority, highest first: reset, `exc_req`, `eret_req`, `stall`, `br_valid`, sequential.
- **reset=0:**
  - `pc_F`=RESET_PC.
  - `Instr_D`=0, `PC_D`=0, `PC4_D`=0, `valid_D`=0, `adel_D`=0.
- **exc_req=1:**
  - `pc_F`←EXC_VECTOR.
  - IF/ID flushed: `Instr_D`=0, `valid_D`=0, `adel_D`=0, `PC_D`←`pc_F`.
  - Overrides `stall`.
- **eret_req=1 and stall=0:**
  - `pc_F`←`epc`.
  - IF/ID flushed as above. `eret` has no delay slot.
- **stall=1:** `pc_F` and all IF/ID outputs hold. `br_valid`, `br_target` and `eret_req` are ignored.
- **br_valid=1:**
  - `pc_F`←`br_target`.
  - IF/ID loads the delay slot normally (no flush).
- **Otherwise:** `pc_F`←`pc_F`+4.
- **IF/ID load** (when not flushed or stalled):
  - `PC_D`←`pc_F`, `PC4_D`←`pc_F`+4, `valid_D`←1.
  - `adel_D`←bad.
  - `Instr_D`←bad ? 0 : `im_rdata`.
- **bad** = `pc_F[1:0]`≠0, or `pc_F`<IM_LO, or `pc_F`>IM_HI.
- A bad fetch does not stop sequencing. The exception unit asserts `exc_req` when the tagged instruction reaches M.
- Arithmetic: 32-bit unsigned; `pc_F`+4 wraps modulo 2^32, no carry out.

## Timing
- Redirect latency: a redirect sampled at edge N is visible on `pc_F` after edge N, and its instruction appears in D after edge N+1.
- Branch in D at cycle N: the delay slot at `pc_F` enters D at N+1 and the target is fetched at N+1.
- `exc_req` and `eret_req` together: `exc_req` wins.
- `exc_req` during stall: redirect still occurs, and the stall is dropped for this block.
- Reset mid-operation: all state returns to reset values at the next edge, regardless of other inputs.
- Outputs are registered only; there is no combinational path from inputs to outputs except `pc_F` to IM.

## Structure
- Shared package `mips_defs`: RESET_PC, EXC_VECTOR, IM_LO, IM_HI, ExcCode constants (ADEL=4), NOP=32'h0.
- One natural sub-module, `if_id_reg`: holds the IF/ID pipeline register with load, hold and flush controls. `fetch_pc` keeps the PC register, the next-PC priority mux and the address check.

## Test plan
- Reset then free-run 3 cycles: `pc_F` reads 3000, 3004, 3008, 300C. After the second edge, `PC4_D`=3004 and `valid_D`=1.
- `beq` in D taken with `br_target`=3020 while `pc_F`=3008: the delay slot at 3008 enters D, then `pc_F`=3020. Not-taken case with `br_target`=300C: sequential fetch continues.
- `stall`=1 for 2 cycles with `br_valid`=1: `pc_F` and IF/ID are unchanged. Release: the redirect is applied the cycle `stall` drops.
- `exc_req`=1 together with `stall`=1 and `eret_req`=1: `pc_F`=4180, `valid_D`=0, `Instr_D`=0.
- `eret_req` with `epc`=3010: `pc_F`=3010 next cycle and IF/ID is a bubble.
- `br_target`=3002 (misaligned) and separately 7000 (out of range): next D has `adel_D`=1 and `Instr_D`=0. `exc_req` then redirects to 4180.
